// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parameterised synchronous FIFO with occupancy, full/empty flags and ack/error pulses
`timescale 1ns/1ps
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] INIT = 3'd0, NO_OP = 3'd1, WRITE = 3'd2, WR_ERROR = 3'd3,
                         READ = 3'd4, RD_ERROR = 3'd5, RDWR = 3'd6, WR_RDERR = 3'd7;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [2:0] state, state_nxt;
  logic do_wr, do_rd;
  assign full  = data_count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = data_count == '0;
  // A write into a full FIFO is allowed when a read frees the slot on the same edge
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;
  always_comb begin
    state_nxt = (do_wr && do_rd) ? RDWR :
                do_wr ? (rd_en ? WR_RDERR : WRITE) :
                do_rd ? READ :
                wr_en ? WR_ERROR :
                rd_en ? RD_ERROR : NO_OP;
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= d_in;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      d_out      <= '0;
      state      <= INIT;
    end else begin
      state      <= state_nxt;
      data_count <= data_count + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_out  <= mem[rd_ptr];
      end
    end
  end
  assign wr_ack = state == WRITE || state == RDWR || state == WR_RDERR;
  assign rd_ack = state == READ || state == RDWR;
  assign wr_err = state == WR_ERROR;
  assign rd_err = state == RD_ERROR || state == WR_RDERR;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO built from the team's resettable register primitives.
- Generalises the fixed 3-bit register to configurable data width and depth.
- Adds occupancy tracking, full/empty flags, per-operation ack/error pulses, and defined simultaneous read/write handling.
- Sits between producer and consumer blocks sharing one clock domain.

Parameters:
DATA_WIDTH, 32, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request, sampled at rising edge
rd_en  input  1  read request, sampled at rising edge
d_in  input  DATA_WIDTH  write data, sampled with wr_en
d_out  output  DATA_WIDTH  registered read data
full  output  1  high when data_count == DEPTH
empty  output  1  high when data_count == 0
data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
wr_ack  output  1  one-cycle pulse: write accepted
wr_err  output  1  one-cycle pulse: write rejected (overflow)
rd_ack  output  1  one-cycle pulse: read performed
rd_err  output  1  one-cycle pulse: read rejected (underflow)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset assertion takes effect immediately, without waiting for a clock edge:
  - wr_ptr=0, rd_ptr=0, data_count=0, d_out=0.
  - All ack/err outputs 0; empty=1, full=0.
  - Memory array is not cleared.
- Reset released: normal operation from the next rising edge.
- Reset asserted mid-burst discards all contents and aborts any pending pulse.
- All state updates on the rising edge of clk only. full and empty decode the data_count register, so they are glitch-free and change only after an edge.
- Operation chosen per edge from (wr_en, rd_en, empty, full) as sampled before the edge:
  - 00: no-op. Pointers, count and d_out hold; all pulses 0.
  - 10, not full: mem[wr_ptr]<=d_in, wr_ptr+1, count+1, wr_ack=1.
  - 10, full: no write, pointers/count hold, wr_err=1.
  - 01, not empty: d_out<=mem[rd_ptr], rd_ptr+1, count-1, rd_ack=1.
  - 01, empty: d_out holds, rd_err=1.
  - 11, empty: write only (count+1, wr_ack=1) and rd_err=1. No data bypass to d_out.
  - 11, full: read and write both performed.
    - d_out gets the oldest word; d_in goes into the freed slot (wr_ptr==rd_ptr before the edge; the read uses the pre-edge contents).
    - Count unchanged (stays DEPTH); wr_ack=1, rd_ack=1.
  - 11, otherwise: both performed, count unchanged, wr_ack=1, rd_ack=1.
- Latency:
  - Read data is valid on d_out immediately after the edge that sampled rd_en, coincident with rd_ack.
  - A written word is readable at the edge following its write edge.
- d_out holds its last read value until the next successful read.
- Pulses are registered, high for exactly one cycle per qualifying edge. Back-to-back requests give a continuous high.
- Pointers wrap modulo DEPTH naturally (ADDR_WIDTH bits). Ordering is strictly first-in first-out across wrap.
- data_count never exceeds DEPTH and never underflows.
- Internal control is a registered state: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR, RDWR.
  - Reset forces INIT.
  - Each edge loads the state matching the operation chosen above.
  - Pulse outputs decode the state: WRITE/RDWR→wr_ack, READ/RDWR→rd_ack, WR_ERROR→wr_err, RD_ERROR→rd_err. The 11-while-empty case sets both wr_ack and rd_err.

Test Plan:
- Reset at t=0, release at 3 ns, run idle for 2 edges → d_out=0, empty=1, full=0, data_count=0, no pulses.
- Write 0x11..0x88 on 8 consecutive edges → wr_ack high 8 cycles; data_count 1..8; full=1 after the 8th edge, empty=0 after the 1st.
- With FIFO full, write 0x99 → wr_err=1 for one cycle, data_count stays 8. Then read 8 times → d_out 0x11..0x88 in order, rd_ack each cycle, empty=1 at the end, 0x99 never appears.
- With FIFO empty, rd_en for one edge → rd_err=1, d_out holds 0x88, data_count=0.
- Pointer wrap and simultaneous operations:
  - Fill 5 words, then 10 edges of simultaneous rd/wr with values 0xA0..0xA9.
  - Expect data_count=5 throughout, wr_ack=rd_ack=1 each cycle, d_out continuing in FIFO order across pointer wrap.
  - When full, simultaneous rd/wr keeps full=1 and returns the oldest word.
- Fill to 6 words, assert reset between clock edges → all outputs return to reset values immediately. After release, a single read gives rd_err=1.
